rolling_sum_mw: RTL and testbench

- Next-generation rolling (boxcar) sum for the FIR trigger path.
- Accepts NSAMP signed samples per clock and sums each group.
- Maintains a sliding sum of the most recent win_len groups; win_len is selectable at run time up to MAXGROUPS.
- Adds pause gating, window-change refill, a per-update strobe and optional output saturation. Feeds the threshold/discriminator stage.

---
 rtl/rolling_sum_mw.sv | 146 ++++++++++++++
 tb/tb_rolling_sum_mw.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/rolling_sum_mw.sv
// Rolling boxcar sum over NSAMP-wide sample groups with run-time window,
// pause gating, window-change refill and optional output clipping.
module rolling_sum_mw #(
  parameter int NSAMP     = 4,
  parameter int INBITS    = 14,
  parameter int MAXGROUPS = 16,
  parameter int OUTBITS   = 20,
  localparam int WLBITS   = $clog2(MAXGROUPS + 1),
  localparam int GSBITS   = INBITS + $clog2(NSAMP),
  localparam int ACCBITS  = GSBITS + WLBITS
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NSAMP*INBITS-1:0]   d_in,
  input  logic                      pause,
  input  logic [WLBITS-1:0]         win_len,
  output logic                      valid_out,
  output logic                      sum_strobe,
  output logic signed [OUTBITS-1:0] sum,
  output logic                      sat
);

  localparam int HB = (MAXGROUPS > 1) ? $clog2(MAXGROUPS) : 1;

  localparam logic [0:0] FILLING = 1'b0;
  localparam logic [0:0] ROLLING = 1'b1;

  logic [0:0]                state;
  logic signed [GSBITS-1:0]  gs;
  logic                      gs_v;
  logic signed [GSBITS-1:0]  hist [MAXGROUPS];
  logic signed [ACCBITS-1:0] acc;
  logic [WLBITS-1:0]         count;
  logic [WLBITS-1:0]         win_len_q;

  logic signed [GSBITS-1:0]  gs_c;
  logic signed [ACCBITS-1:0] acc_nx;
  logic signed [ACCBITS-1:0] sub;
  logic signed [OUTBITS-1:0] sum_nx;
  logic                      sat_nx;
  logic [WLBITS-1:0]         wl_c;
  logic [WLBITS-1:0]         cnt_nx;
  logic [HB-1:0]             tap;
  logic                      wl_chg;

  always_comb begin
    gs_c = '0;
    for (int i = 0; i < NSAMP; i++) begin
      gs_c = gs_c + GSBITS'($signed(d_in[i*INBITS +: INBITS]));
    end
  end

  always_comb begin
    wl_c = win_len;
    if (win_len == '0) begin
      wl_c = WLBITS'(1);
    end else if (win_len > WLBITS'(MAXGROUPS)) begin
      wl_c = WLBITS'(MAXGROUPS);
    end
  end

  assign wl_chg = (wl_c != win_len_q);
  assign cnt_nx = count + 1'b1;
  assign tap    = HB'(win_len_q - 1'b1);

  // Oldest in-window group leaves before the history shift.
  always_comb begin
    sub = '0;
    if (state == ROLLING) begin
      sub = ACCBITS'(hist[tap]);
    end
    acc_nx = acc + ACCBITS'(gs) - sub;
  end

  generate
    if (OUTBITS >= ACCBITS) begin : g_ext
      assign sum_nx = OUTBITS'(acc_nx);
      assign sat_nx = 1'b0;
    end else begin : g_clip
      localparam logic signed [ACCBITS-1:0] HI =
        ACCBITS'((64'sd1 <<< (OUTBITS - 1)) - 64'sd1);
      localparam logic signed [ACCBITS-1:0] LO = ~HI;
      always_comb begin
        sum_nx = acc_nx[OUTBITS-1:0];
        sat_nx = 1'b0;
        if (acc_nx > HI) begin
          sum_nx = HI[OUTBITS-1:0];
          sat_nx = 1'b1;
        end else if (acc_nx < LO) begin
          sum_nx = LO[OUTBITS-1:0];
          sat_nx = 1'b1;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= FILLING;
      gs         <= '0;
      gs_v       <= 1'b0;
      acc        <= '0;
      count      <= '0;
      win_len_q  <= wl_c;
      valid_out  <= 1'b0;
      sum_strobe <= 1'b0;
      sum        <= '0;
      sat        <= 1'b0;
      for (int i = 0; i < MAXGROUPS; i++) begin
        hist[i] <= '0;
      end
    end else begin
      gs         <= gs_c;
      gs_v       <= !pause;
      sum_strobe <= 1'b0;
      if (gs_v) begin
        hist[0] <= gs;
        for (int i = 1; i < MAXGROUPS; i++) begin
          hist[i] <= hist[i-1];
        end
      end
      if (wl_chg) begin
        win_len_q <= wl_c;
        acc       <= '0;
        count     <= '0;
        valid_out <= 1'b0;
        state     <= FILLING;
        sum       <= '0;
        sat       <= 1'b0;
      end else if (gs_v) begin
        acc        <= acc_nx;
        sum        <= sum_nx;
        sat        <= sat_nx;
        sum_strobe <= 1'b1;
        if (state == FILLING) begin
          count <= cnt_nx;
          if (cnt_nx == win_len_q) begin
            state     <= ROLLING;
            valid_out <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_rolling_sum_mw.sv
// Directed bench for rolling_sum_mw: window-of-groups queue model checked
// every cycle, plus literal checkpoints.
module tb_rolling_sum_mw;

  localparam int NSAMP  = 4;
  localparam int INBITS = 14;
  localparam int MAXG   = 8;
  localparam int OUTB   = 18;
  localparam int WLB    = $clog2(MAXG + 1);

  logic                     clk = 1'b0;
  logic                     reset_n;
  logic [NSAMP*INBITS-1:0]  d_in;
  logic                     pause;
  logic [WLB-1:0]           win_len;
  logic                     valid_out;
  logic                     sum_strobe;
  logic signed [OUTB-1:0]   sum;
  logic                     sat;

  int n_pass = 0;
  int n_chk  = 0;

  rolling_sum_mw #(
    .NSAMP(NSAMP), .INBITS(INBITS), .MAXGROUPS(MAXG), .OUTBITS(OUTB)
  ) dut (
    .clk(clk), .reset_n(reset_n), .d_in(d_in), .pause(pause),
    .win_len(win_len), .valid_out(valid_out), .sum_strobe(sum_strobe),
    .sum(sum), .sat(sat)
  );

  always #5 clk = ~clk;

  // Model: the window is the list of groups accepted since the last refill.
  int  m_win[$];
  int  m_wl;
  int  m_pend;
  bit  m_pend_v;
  bit  m_valid, m_strobe, m_sat;
  int  m_sum;
  bit  m_live = 0;

  function automatic int clampw(int w);
    if (w == 0) return 1;
    if (w > MAXG) return MAXG;
    return w;
  endfunction

  function automatic int grp_sum();
    int s = 0;
    for (int i = 0; i < NSAMP; i++) begin
      logic signed [INBITS-1:0] x;
      x = d_in[i*INBITS +: INBITS];
      s += int'(x);
    end
    return s;
  endfunction

  always @(posedge clk) begin
    if (!reset_n) begin
      m_win.delete();
      m_wl = clampw(int'(win_len));
      m_pend_v = 0;
      m_pend = 0;
      m_valid = 0; m_strobe = 0; m_sat = 0; m_sum = 0;
      m_live = 1;
    end else begin
      m_strobe = 0;
      if (clampw(int'(win_len)) != m_wl) begin
        m_wl = clampw(int'(win_len));
        m_win.delete();
        m_valid = 0; m_sum = 0; m_sat = 0;
      end else if (m_pend_v) begin
        int t;
        m_win.push_back(m_pend);
        if (m_win.size() > m_wl) void'(m_win.pop_front());
        t = 0;
        foreach (m_win[i]) t += m_win[i];
        m_sat = 0;
        if (t > (1 << (OUTB-1)) - 1) begin
          t = (1 << (OUTB-1)) - 1; m_sat = 1;
        end else if (t < -(1 << (OUTB-1))) begin
          t = -(1 << (OUTB-1)); m_sat = 1;
        end
        m_sum = t;
        m_strobe = 1;
        if (m_win.size() == m_wl) m_valid = 1;
      end
      m_pend = grp_sum();
      m_pend_v = !pause;
    end
  end

  function automatic void chk(string nm, int got, int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
  endfunction

  always @(negedge clk) begin
    if (m_live) begin
      chk("model valid_out", int'(valid_out), int'(m_valid));
      chk("model sum_strobe", int'(sum_strobe), int'(m_strobe));
      chk("model sum", int'(sum), m_sum);
      chk("model sat", int'(sat), int'(m_sat));
    end
  end

  task automatic set_all(input int v);
    for (int i = 0; i < NSAMP; i++) d_in[i*INBITS +: INBITS] = INBITS'(v);
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic lit(string nm, int s, int v, int st);
    chk({nm, " sum"}, int'(sum), s);
    chk({nm, " valid"}, int'(valid_out), v);
    chk({nm, " strobe"}, int'(sum_strobe), st);
  endtask

  initial begin
    reset_n = 0; win_len = 4; pause = 0; set_all(100);
    step();
    lit("reset", 0, 0, 0);
    chk("reset sat", int'(sat), 0);

    // Fill timing
    reset_n = 1;
    step();
    lit("fill0", 0, 0, 0);
    step(); lit("fill1", 400, 0, 1);
    step(); lit("fill2", 800, 0, 1);
    step(); lit("fill3", 1200, 0, 1);
    step(); lit("fill4", 1600, 1, 1);
    step(3); lit("steady", 1600, 1, 1);

    // Rolling down to zero
    set_all(0);
    step(); lit("roll0", 1600, 1, 1);
    step(); lit("roll1", 1200, 1, 1);
    step(); lit("roll2", 800, 1, 1);
    step(); lit("roll3", 400, 1, 1);
    step(); lit("roll4", 0, 1, 1);

    // Pause gaps with win_len=2
    pause = 1;
    step();
    win_len = 2;
    step(); lit("chg2", 0, 0, 0);
    set_all(100); pause = 0;
    step();
    pause = 1;
    step(); lit("gap400", 400, 0, 1);
    step(); lit("paused1", 400, 0, 0);
    step(); lit("paused2", 400, 0, 0);
    set_all(-50); pause = 0;
    step();
    pause = 1;
    step(); lit("gap200", 200, 1, 1);
    step(2); lit("frozen", 200, 1, 0);

    // Window change 4 -> 2
    pause = 0; set_all(100); win_len = 4;
    step(7); lit("w4", 1600, 1, 1);
    win_len = 2;
    step(); lit("w2chg", 0, 0, 0);
    step(); lit("w2a", 400, 0, 1);
    step(); lit("w2b", 800, 1, 1);
    step(); lit("w2c", 800, 1, 1);

    // win_len=0 acts as 1
    win_len = 0;
    step(); lit("w0chg", 0, 0, 0);
    set_all(7);
    step(); lit("w0a", 400, 1, 1);
    step(); lit("w0b", 28, 1, 1);

    // Clamp 12 -> 8 and clipping
    win_len = 12; set_all(-8192);
    step(); lit("w12chg", 0, 0, 0);
    step(); lit("neg1", -32768, 0, 1);
    step(3);
    lit("neg4", -131072, 0, 1);
    chk("neg4 sat", int'(sat), 0);
    step(); chk("neg5 sat", int'(sat), 1);
    step(3);
    lit("neg8", -131072, 1, 1);
    chk("neg8 sat", int'(sat), 1);
    // acc is -262144; zeros lift it by 32768 per group
    set_all(0);
    step(4);
    chk("rec3 sat", int'(sat), 1);
    step(); chk("rec4 sum", int'(sum), -131072);
    chk("rec4 sat", int'(sat), 0);
    step(); chk("rec5 sum", int'(sum), -98304);

    // Reset mid-operation
    set_all(100);
    step(8);
    reset_n = 0;
    step(); lit("rst2", 0, 0, 0);
    chk("rst2 sat", int'(sat), 0);
    reset_n = 1;
    step(8); lit("refill7", 2800, 0, 1);
    step(); lit("refill8", 3200, 1, 1);
    step(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
